pipe_stage_n: RTL and testbench

Parametrised pipeline-register stage for the five-stage CPU, replacing the fixed per-boundary flop banks (FD/DX/XM/MW) with one configurable block. It carries a data field and a control field through DEPTH register slots and tracks a valid bit per slot. It adds stall (hold), flush (bubble insertion), occupancy reporting and a sticky halt detector. It sits between any two pipeline stages; the hazard unit drives stall and flush.

---
 rtl/pipe_pkg.sv | 51 +++++
 rtl/pipe_slot.sv | 42 ++++
 rtl/pipe_stage_n.sv | 92 +++++++++
 tb/tb_pipe_stage_n.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-register stage.
// - Default payload widths.
// - Bit positions of the fields inside the control word.
// - Helpers that pack a control struct into the raw control word and unpack it again.
package pipe_pkg;

  localparam int DATA_W = 64;
  localparam int CTRL_W = 8;

  localparam int CTRL_REGWRITE     = 0;
  localparam int CTRL_WRITEREG_LSB = 1;
  localparam int CTRL_WRITEREG_MSB = 3;
  localparam int CTRL_JUMP         = 4;
  localparam int CTRL_BR           = 5;
  localparam int CTRL_REGSRC_LSB   = 6;
  localparam int CTRL_REGSRC_MSB   = 6;
  localparam int CTRL_HALT         = 7;

  typedef struct packed {
    logic       halt;
    logic [0:0] reg_src;
    logic       br;
    logic       jump;
    logic [2:0] write_reg;
    logic       reg_write;
  } ctrl_t;

  function automatic logic [CTRL_W-1:0] pack_ctrl(input ctrl_t f);
    logic [CTRL_W-1:0] v;
    v = '0;
    v[CTRL_REGWRITE] = f.reg_write;
    v[CTRL_WRITEREG_MSB:CTRL_WRITEREG_LSB] = f.write_reg;
    v[CTRL_JUMP] = f.jump;
    v[CTRL_BR] = f.br;
    v[CTRL_REGSRC_MSB:CTRL_REGSRC_LSB] = f.reg_src;
    v[CTRL_HALT] = f.halt;
    return v;
  endfunction

  function automatic ctrl_t unpack_ctrl(input logic [CTRL_W-1:0] v);
    ctrl_t f;
    f.reg_write = v[CTRL_REGWRITE];
    f.write_reg = v[CTRL_WRITEREG_MSB:CTRL_WRITEREG_LSB];
    f.jump      = v[CTRL_JUMP];
    f.br        = v[CTRL_BR];
    f.reg_src   = v[CTRL_REGSRC_MSB:CTRL_REGSRC_LSB];
    f.halt      = v[CTRL_HALT];
    return f;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One register slot of the pipeline stage: valid, data and control flops.
// Reset is asynchronous and active-low on every flop.
// Ports:
//   clk, rst                      - clock and reset
//   flush, stall                  - hazard controls; flush has priority over stall
//   load_valid/load_data/load_ctrl - value captured on an advancing edge
//   valid/data/ctrl               - registered slot contents
module pipe_slot import pipe_pkg::*; #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic [CTRL_W-1:0] load_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  // ctrl is forced to zero whenever valid is zero, so a bubble can never
  // assert regWrite, halt, jump or br downstream. data is left alone on
  // flush because nothing consumes it without valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      data  <= '0;
      ctrl  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (!stall) begin
      valid <= load_valid;
      data  <= load_data;
      ctrl  <= load_valid ? load_ctrl : '0;
    end
  end

endmodule

// File: rtl/pipe_stage_n.sv
// Parametrised pipeline-register stage: DEPTH slots of {valid, data, ctrl},
// with stall, flush, occupancy count and a sticky halt detector.
// DEPTH is expected to be in the range 1..8.
// Ports:
//   clk, rst                    - clock, async active-low reset
//   in_valid/in_data/in_ctrl    - upstream instruction
//   stall, flush                - hazard-unit controls (flush wins)
//   out_valid/out_data/out_ctrl - last slot contents
//   occupancy                   - number of valid slots
//   halted                      - set once a valid halt leaves the stage
module pipe_stage_n import pipe_pkg::*; #(
  parameter int DATA_W   = pipe_pkg::DATA_W,
  parameter int CTRL_W   = pipe_pkg::CTRL_W,
  parameter int DEPTH    = 1,
  parameter int HALT_BIT = pipe_pkg::CTRL_HALT,
  localparam int OCC_W   = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [OCC_W-1:0]  occupancy,
  output logic              halted
);

  logic              slot_valid [DEPTH];
  logic [DATA_W-1:0] slot_data  [DEPTH];
  logic [CTRL_W-1:0] slot_ctrl  [DEPTH];

  // Once halted, new instructions are accepted only as bubbles so the
  // stage drains and stays empty.
  logic gated_valid;
  assign gated_valid = in_valid & ~halted;

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    if (i == 0) begin : g_head
      pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_slot (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .stall      (stall),
        .load_valid (gated_valid),
        .load_data  (in_data),
        .load_ctrl  (in_ctrl),
        .valid      (slot_valid[i]),
        .data       (slot_data[i]),
        .ctrl       (slot_ctrl[i])
      );
    end else begin : g_body
      pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_slot (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .stall      (stall),
        .load_valid (slot_valid[i-1]),
        .load_data  (slot_data[i-1]),
        .load_ctrl  (slot_ctrl[i-1]),
        .valid      (slot_valid[i]),
        .data       (slot_data[i]),
        .ctrl       (slot_ctrl[i])
      );
    end
  end

  assign out_valid = slot_valid[DEPTH-1];
  assign out_data  = slot_data[DEPTH-1];
  assign out_ctrl  = slot_ctrl[DEPTH-1];

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + OCC_W'(slot_valid[i]);
    end
  end

  // The halt counts only on the edge where it is actually consumed, so a
  // halt parked at the output under stall, or killed by flush, is ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halted <= 1'b0;
    end else if (out_valid && out_ctrl[HALT_BIT] && !stall && !flush) begin
      halted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_n.sv
module tb_pipe_stage_n;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic [7:0]  in_ctrl = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;

  logic        d1_valid, d2_valid, d3_valid;
  logic [63:0] d1_data, d2_data, d3_data;
  logic [7:0]  d1_ctrl, d2_ctrl, d3_ctrl;
  logic [0:0]  d1_occ;
  logic [1:0]  d2_occ, d3_occ;
  logic        d1_halted, d2_halted, d3_halted;

  always #5 clk = ~clk;

  pipe_stage_n #(.DEPTH(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ctrl(in_ctrl),
    .stall(stall), .flush(flush), .out_valid(d1_valid), .out_data(d1_data),
    .out_ctrl(d1_ctrl), .occupancy(d1_occ), .halted(d1_halted));

  pipe_stage_n #(.DEPTH(2)) u_d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ctrl(in_ctrl),
    .stall(stall), .flush(flush), .out_valid(d2_valid), .out_data(d2_data),
    .out_ctrl(d2_ctrl), .occupancy(d2_occ), .halted(d2_halted));

  pipe_stage_n #(.DEPTH(3)) u_d3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ctrl(in_ctrl),
    .stall(stall), .flush(flush), .out_valid(d3_valid), .out_data(d3_data),
    .out_ctrl(d3_ctrl), .occupancy(d3_occ), .halted(d3_halted));

  int n_vec = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  c;
  } sb_t;
  sb_t sb_q[$];
  bit  sb_en = 0;

  typedef struct {
    logic        v;
    logic [63:0] d;
    logic [7:0]  c;
    logic        s;
    logic        f;
    logic        ev;
    logic [63:0] ed;
    logic [7:0]  ec;
    logic [1:0]  eo;
  } vec_t;
  vec_t tbl[19];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, run the depth-2 scoreboard, then return
  // 1 time unit after the rising edge so outputs are sampled off the edge.
  task automatic step(input logic v, input logic [63:0] d, input logic [7:0] c,
                      input logic s, input logic f);
    sb_t e;
    in_valid = v; in_data = d; in_ctrl = c; stall = s; flush = f;
    if (sb_en) begin
      if (f) begin
        sb_q.delete();
      end else if (!s) begin
        if (d2_valid) begin
          if (sb_q.size() == 0) begin
            check("sb_underflow", 64'd1, 64'd0);
          end else begin
            e = sb_q.pop_front();
            check("sb_data", d2_data, e.d);
            check("sb_ctrl", {56'd0, d2_ctrl}, {56'd0, e.c});
          end
        end
        if (v) sb_q.push_back('{d: d, c: c});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    in_valid = 0; in_data = '0; in_ctrl = '0; stall = 0; flush = 0;
    rst = 0;
    @(posedge clk);
    #1;
    rst = 1;
  endtask

  initial begin
    // Reset held with garbage valid input on the depth-3 stage.
    rst = 0;
    in_valid = 1; in_data = 64'hDEAD_BEEF; in_ctrl = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {63'd0, d3_valid}, 64'd0);
    check("rst_ctrl", {56'd0, d3_ctrl}, 64'd0);
    check("rst_data", d3_data, 64'd0);
    check("rst_occ", {62'd0, d3_occ}, 64'd0);
    check("rst_halted", {63'd0, d3_halted}, 64'd0);
    rst = 1;

    step(1, 64'h1234, 8'h01, 0, 0);
    check("lat3_e1_valid", {63'd0, d3_valid}, 64'd0);
    step(0, 64'h0, 8'h00, 0, 0);
    check("lat3_e2_valid", {63'd0, d3_valid}, 64'd0);
    step(0, 64'h0, 8'h00, 0, 0);
    check("lat3_e3_valid", {63'd0, d3_valid}, 64'd1);
    check("lat3_e3_data", d3_data, 64'h1234);

    // Depth-2 table: streaming, stall, flush+stall, bubble zeroing.
    tbl[0]  = '{1, 64'h1,  8'h01, 0, 0, 0, 64'h0,  8'h00, 2'd1};
    tbl[1]  = '{1, 64'h2,  8'h02, 0, 0, 1, 64'h1,  8'h01, 2'd2};
    tbl[2]  = '{1, 64'h3,  8'h03, 0, 0, 1, 64'h2,  8'h02, 2'd2};
    tbl[3]  = '{1, 64'h4,  8'h04, 0, 0, 1, 64'h3,  8'h03, 2'd2};
    tbl[4]  = '{0, 64'h0,  8'h00, 0, 0, 1, 64'h4,  8'h04, 2'd1};
    tbl[5]  = '{0, 64'h0,  8'h00, 0, 0, 0, 64'h0,  8'h00, 2'd0};
    tbl[6]  = '{1, 64'hA0, 8'h05, 0, 0, 0, 64'h0,  8'h00, 2'd1};
    tbl[7]  = '{1, 64'hB0, 8'h03, 0, 0, 1, 64'hA0, 8'h05, 2'd2};
    tbl[8]  = '{1, 64'hC0, 8'h07, 1, 0, 1, 64'hA0, 8'h05, 2'd2};
    tbl[9]  = '{1, 64'hC0, 8'h07, 1, 0, 1, 64'hA0, 8'h05, 2'd2};
    tbl[10] = '{1, 64'hC0, 8'h07, 1, 0, 1, 64'hA0, 8'h05, 2'd2};
    tbl[11] = '{0, 64'h0,  8'h00, 0, 0, 1, 64'hB0, 8'h03, 2'd1};
    tbl[12] = '{0, 64'h0,  8'h00, 0, 0, 0, 64'h0,  8'h00, 2'd0};
    tbl[13] = '{1, 64'hE0, 8'h09, 0, 0, 0, 64'h0,  8'h00, 2'd1};
    tbl[14] = '{1, 64'hF0, 8'h0A, 0, 0, 1, 64'hE0, 8'h09, 2'd2};
    tbl[15] = '{1, 64'hD0, 8'h0B, 1, 1, 0, 64'h0,  8'h00, 2'd0};
    tbl[16] = '{0, 64'h0,  8'h00, 0, 0, 0, 64'h0,  8'h00, 2'd0};
    tbl[17] = '{0, 64'h55, 8'hFF, 0, 0, 0, 64'h0,  8'h00, 2'd0};
    tbl[18] = '{0, 64'h66, 8'hFF, 0, 0, 0, 64'h0,  8'h00, 2'd0};

    reset_pulse();
    sb_q.delete();
    sb_en = 1;
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].c, tbl[i].s, tbl[i].f);
      check($sformatf("tbl%0d_valid", i), {63'd0, d2_valid}, {63'd0, tbl[i].ev});
      check($sformatf("tbl%0d_ctrl", i), {56'd0, d2_ctrl}, {56'd0, tbl[i].ec});
      check($sformatf("tbl%0d_occ", i), {62'd0, d2_occ}, {62'd0, tbl[i].eo});
      if (tbl[i].ev) check($sformatf("tbl%0d_data", i), d2_data, tbl[i].ed);
    end
    sb_en = 0;
    check("sb_leftover", 64'(sb_q.size()), 64'd0);
    check("tbl_halted", {63'd0, d2_halted}, 64'd0);

    // Halt on the depth-1 stage followed by more valid instructions.
    reset_pulse();
    step(1, 64'h100, 8'h80, 0, 0);
    check("halt_out_valid", {63'd0, d1_valid}, 64'd1);
    check("halt_out_ctrl", {56'd0, d1_ctrl}, 64'h80);
    check("halt_not_yet", {63'd0, d1_halted}, 64'd0);
    step(1, 64'h101, 8'h01, 0, 0);
    check("halt_set", {63'd0, d1_halted}, 64'd1);
    check("halt_next_data", d1_data, 64'h101);
    step(1, 64'h102, 8'h01, 0, 0);
    check("halt_drain_valid", {63'd0, d1_valid}, 64'd0);
    check("halt_drain_ctrl", {56'd0, d1_ctrl}, 64'd0);
    check("halt_drain_occ", {63'd0, d1_occ}, 64'd0);
    step(1, 64'h103, 8'h80, 0, 1);
    check("halt_sticky", {63'd0, d1_halted}, 64'd1);

    // Halt parked at the output under stall.
    reset_pulse();
    step(1, 64'h200, 8'h80, 0, 0);
    for (int k = 0; k < 2; k++) begin
      step(1, 64'h201, 8'h01, 1, 0);
      check($sformatf("hstall%0d_halted", k), {63'd0, d1_halted}, 64'd0);
      check($sformatf("hstall%0d_ctrl", k), {56'd0, d1_ctrl}, 64'h80);
    end
    step(0, 64'h0, 8'h00, 0, 0);
    check("hstall_release_halted", {63'd0, d1_halted}, 64'd1);
    check("hstall_release_occ", {63'd0, d1_occ}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
